adc_word_packer: RTL and testbench
==================================

ADC_WORD_PACKER -- requirements
Module: adc_word_packer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of ADC channels.
REQ-002 SHALL have parameter SW, default 16: sample width in bits.
REQ-003 SHALL have parameter DEPTH, default 2: samples per channel per output word; power of two, 1..8.
REQ-004 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-005 SHALL have port clr, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port wen, input, 1: din holds a valid sample set this cycle.
REQ-007 SHALL have port din, input, NCH*SW: channel c at [c*SW +: SW].
REQ-008 SHALL have port mode, input, 1: 0 = all channels interleaved; 1 = channel 0 only, dense.
REQ-009 SHALL have port flush, input, 1: emit the partial word now.
REQ-010 SHALL have port dout, output, NCH*SW*DEPTH: packed word.
REQ-011 SHALL have port dout_valid, output, 1: dout holds an unconsumed word.
REQ-012 SHALL have port dout_ready, input, 1: sink accepts dout.
REQ-013 SHALL have port overflow, output, 1: sticky; a completed word was dropped.
REQ-014 SHALL have port drop_cnt, output, 8: saturating count of dropped words.
REQ-015 SHALL have port clr_ovf, input, 1: synchronous clear of overflow and drop_cnt.

Function
REQ-016 SHALL accept samples unconditionally, because the ADC cannot stall; wen low holds all assembly state.
REQ-017 SHALL, in mode 0, write channel c, slot s into bits [(c*DEPTH+s)*SW +: SW]; the slot counter runs 0..DEPTH-1.
REQ-018 SHALL, in mode 1, write channel 0 at linear slot k into bits [k*SW +: SW]; k runs 0..NCH*DEPTH-1; din channels 1..NCH-1 are ignored.
REQ-019 SHALL latch mode only while the slot counter is 0; a mode change mid-word takes effect on the next word.
REQ-020 SHALL, on the edge that accepts the last slot, load the complete word into dout and set dout_valid; there are zero added cycles of latency, and the counter returns to 0.
REQ-021 SHALL transfer a word on any cycle with dout_valid=1 and dout_ready=1; dout_valid drops next edge unless a new word loads on that edge.
REQ-022 SHALL hold dout stable while dout_valid=1 and dout_ready=0.
REQ-023 SHALL, when a word completes while dout_valid=1 and dout_ready=0:
- discard the new word and keep dout unchanged;
- set overflow;
- increment drop_cnt, saturating at 255;
- reset the counter to 0.
REQ-024 SHALL, when a word completes on a transfer cycle, load the new word and keep dout_valid=1; this is not an overflow.
REQ-025 SHALL, on flush=1 with counter>0 or wen=1:
- emit the accumulated slots, including any sample accepted that cycle;
- leave unfilled slots zero;
- apply REQ-020/023/024 to this emit;
- reset the counter.
REQ-026 SHALL treat flush=1 with counter=0 and wen=0 as a no-op.
REQ-027 SHALL zero the assembly register whenever the counter returns to 0.
REQ-028 SHALL give clr_ovf priority over a simultaneous overflow event.

Reset
REQ-029 SHALL, on clr=0, immediately clear the following regardless of clk: counter, latched mode, assembly register, dout, dout_valid, overflow and drop_cnt.
REQ-030 SHALL discard a partial word on reset mid-word; the first sample after release goes to slot 0.
REQ-031 SHALL release reset cleanly on the first clk edge after clr rises; no extra idle cycle.

Structure
REQ-032 SHALL take the SW default, the mode encoding constants (MODE_INTERLEAVED=0, MODE_SINGLE=1) and the DEPTH legality check from shared package dso_pkg.
REQ-033 SHALL size the counter as clog2(NCH*DEPTH), minimum 1 bit.
REQ-034 SHALL place the output register, valid/ready logic and overflow accounting in one sub-module, pack_out_stage.

Verification
REQ-035 SHALL pass: NCH=4, SW=16, DEPTH=2, mode 0, ready=1; din=64'h4444_3333_2222_1111 then 64'h8888_7777_6666_5555 -> dout=128'h8888_4444_7777_3333_6666_2222_5555_1111, valid for 1 cycle, on the 2nd wen edge.
REQ-036 SHALL pass: mode 1; eight wen cycles with ch0=16'h0001..16'h0008 -> dout=128'h0008_0007_0006_0005_0004_0003_0002_0001.
REQ-037 SHALL pass: ready=0; three complete words -> dout keeps word 1, overflow=1, drop_cnt=2; clr_ovf -> overflow=0, drop_cnt=0.
REQ-038 SHALL pass: mode 0; one wen with 64'hAAAA_BBBB_CCCC_DDDD plus flush next cycle -> dout=128'h0000_AAAA_0000_BBBB_0000_CCCC_0000_DDDD.
REQ-039 SHALL pass: clr low after one sample -> dout_valid=0 immediately; after release a full word contains only post-reset samples.
REQ-040 SHALL pass: word completes on a transfer cycle -> dout_valid stays 1, new word present, overflow=0.

Source files
------------

// File: rtl/dso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dso_pkg
// Purpose  : Shared constants for the DSO capture path: default sample width,
//            packing-mode encoding and the DEPTH legality check.
// Revision : 1.0
// ============================================================================
package dso_pkg;

    localparam int SW_DEFAULT = 16;

    typedef enum logic {
        MODE_INTERLEAVED = 1'b0,
        MODE_SINGLE      = 1'b1
    } pack_mode_e;

    function automatic bit depth_is_legal(input int depth);
        return (depth == 1) || (depth == 2) || (depth == 4) || (depth == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : pack_out_stage
// Purpose  : Output word register with valid/ready handshake and drop
//            accounting (sticky overflow, saturating drop counter).
// Revision : 1.0
// ============================================================================
module pack_out_stage #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_word,
    input  logic          i_ready,
    input  logic          i_clr_ovf,
    output logic [DW-1:0] o_dout,
    output logic          o_valid,
    output logic          o_overflow,
    output logic [7:0]    o_drop_cnt
);

    logic [DW-1:0] r_dout_q;
    logic [DW-1:0] w_dout_d;
    logic          r_valid_q;
    logic          w_valid_d;
    logic          r_ovf_q;
    logic          w_ovf_d;
    logic [7:0]    r_drop_q;
    logic [7:0]    w_drop_d;
    logic          w_xfer;

    always_comb begin
        w_xfer    = r_valid_q & i_ready;
        w_dout_d  = r_dout_q;
        w_valid_d = r_valid_q;
        w_ovf_d   = r_ovf_q;
        w_drop_d  = r_drop_q;

        if (i_load) begin
            // A pending word being consumed this cycle frees the slot.
            if (!r_valid_q || i_ready) begin
                w_dout_d  = i_word;
                w_valid_d = 1'b1;
            end else begin
                w_ovf_d = 1'b1;
                if (r_drop_q != 8'hFF) begin
                    w_drop_d = r_drop_q + 8'd1;
                end
            end
        end else if (w_xfer) begin
            w_valid_d = 1'b0;
        end

        if (i_clr_ovf) begin
            w_ovf_d  = 1'b0;
            w_drop_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_q  <= '0;
            r_valid_q <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_drop_q  <= 8'd0;
        end else begin
            r_dout_q  <= w_dout_d;
            r_valid_q <= w_valid_d;
            r_ovf_q   <= w_ovf_d;
            r_drop_q  <= w_drop_d;
        end
    end

    assign o_dout     = r_dout_q;
    assign o_valid    = r_valid_q;
    assign o_overflow = r_ovf_q;
    assign o_drop_cnt = r_drop_q;

endmodule
`default_nettype wire

// File: rtl/adc_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : adc_word_packer
// Purpose  : Packs multi-channel ADC sample sets into wide output words,
//            interleaved across channels or dense from channel 0.
// Revision : 1.0
// ============================================================================
module adc_word_packer
    import dso_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int SW    = SW_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    wen,
    input  logic [NCH*SW-1:0]       din,
    input  logic                    mode,
    input  logic                    flush,
    output logic [NCH*SW*DEPTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    overflow,
    output logic [7:0]              drop_cnt,
    input  logic                    clr_ovf
);

    localparam int c_slots = NCH * DEPTH;
    localparam int c_dw    = NCH * SW * DEPTH;
    localparam int c_cw    = (c_slots > 1) ? $clog2(c_slots) : 1;

    generate
        if (!depth_is_legal(DEPTH)) begin : g_depth_illegal
            $error("adc_word_packer: DEPTH must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [c_cw-1:0] r_cnt_q;
    logic [c_cw-1:0] w_cnt_d;
    pack_mode_e      r_mode_q;
    pack_mode_e      w_mode_d;
    logic [c_dw-1:0] r_asm_q;
    logic [c_dw-1:0] w_asm_d;

    pack_mode_e      w_mode_eff;
    logic [c_cw-1:0] w_last;
    logic [c_dw-1:0] w_fill;
    logic            w_emit;

    always_comb begin
        // Mode is sampled only at the start of a word.
        w_mode_eff = (r_cnt_q == '0) ? pack_mode_e'(mode) : r_mode_q;
        w_last     = (w_mode_eff == MODE_SINGLE) ? c_cw'(c_slots - 1) : c_cw'(DEPTH - 1);

        w_fill = r_asm_q;
        if (wen) begin
            if (w_mode_eff == MODE_SINGLE) begin
                w_fill[int'(r_cnt_q)*SW +: SW] = din[SW-1:0];
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    w_fill[(c*DEPTH + int'(r_cnt_q))*SW +: SW] = din[c*SW +: SW];
                end
            end
        end

        w_emit = (wen && (r_cnt_q == w_last)) || (flush && (wen || (r_cnt_q != '0)));

        w_cnt_d  = r_cnt_q;
        w_asm_d  = w_fill;
        w_mode_d = w_mode_eff;
        if (w_emit) begin
            w_cnt_d = '0;
            w_asm_d = '0;
        end else if (wen) begin
            w_cnt_d = r_cnt_q + c_cw'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt_q  <= '0;
            r_mode_q <= MODE_INTERLEAVED;
            r_asm_q  <= '0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_mode_q <= w_mode_d;
            r_asm_q  <= w_asm_d;
        end
    end

    pack_out_stage #(
        .DW (c_dw)
    ) u_out (
        .clk        (clk),
        .rst_n      (clr),
        .i_load     (w_emit),
        .i_word     (w_fill),
        .i_ready    (dout_ready),
        .i_clr_ovf  (clr_ovf),
        .o_dout     (dout),
        .o_valid    (dout_valid),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_word_packer
// Purpose  : Self-checking bench for adc_word_packer (directed table,
//            corner sequences and randomized run against a reference model).
// Revision : 1.0
// ============================================================================
module tb_adc_word_packer;

    localparam int NCH   = 4;
    localparam int SW    = 16;
    localparam int DEPTH = 2;
    localparam int IW    = NCH * SW;
    localparam int DW    = NCH * SW * DEPTH;
    localparam int SLOTS = NCH * DEPTH;

    localparam logic [DW-1:0] W35 = 128'h8888_4444_7777_3333_6666_2222_5555_1111;
    localparam logic [DW-1:0] W36 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [DW-1:0] W38 = 128'h0000_AAAA_0000_BBBB_0000_CCCC_0000_DDDD;
    localparam logic [DW-1:0] W37 = 128'h0008_0004_0007_0003_0006_0002_0005_0001;
    localparam logic [DW-1:0] W40 = 128'h00D1_00D0_00C1_00C0_00B1_00B0_00A1_00A0;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          wen = 1'b0;
    logic [IW-1:0] din = '0;
    logic          mode = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clr_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    adc_word_packer #(
        .NCH   (NCH),
        .SW    (SW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .wen        (wen),
        .din        (din),
        .mode       (mode),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [IW-1:0] din;
        logic          mode;
        logic          flush;
        logic          ready;
        logic          clr_ovf;
        logic          ev;
        logic [DW-1:0] ed;
        logic          eo;
        logic [7:0]    edc;
    } vec_t;

    vec_t vecs[$];

    // Reference model: collects whole sample sets and builds words from the
    // slot placement rules when a word is due.
    logic [IW-1:0] m_samp [SLOTS];
    int            m_n;
    logic          m_mode;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic          e_ovf;
    int            e_drop;

    task automatic add_vec(input logic w, input logic [IW-1:0] d, input logic md,
                           input logic fl, input logic rd, input logic co,
                           input logic ev, input logic [DW-1:0] ed,
                           input logic eo, input logic [7:0] edc);
        vec_t v;
        v.wen = w; v.din = d; v.mode = md; v.flush = fl; v.ready = rd;
        v.clr_ovf = co; v.ev = ev; v.ed = ed; v.eo = eo; v.edc = edc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [DW-1:0] ed,
                              input logic eo, input logic [7:0] edc);
        chk({tag, ".dout_valid"}, DW'(dout_valid), DW'(ev));
        chk({tag, ".dout"}, dout, ed);
        chk({tag, ".overflow"}, DW'(overflow), DW'(eo));
        chk({tag, ".drop_cnt"}, DW'(drop_cnt), DW'(edc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_n = 0; m_mode = 1'b0;
        e_valid = 1'b0; e_dout = '0; e_ovf = 1'b0; e_drop = 0;
    endtask

    function automatic logic [DW-1:0] build_word(input logic md, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            if (md == 1'b0) begin
                for (int c = 0; c < NCH; c++) w[(c*DEPTH + k)*SW +: SW] = m_samp[k][c*SW +: SW];
            end else begin
                w[k*SW +: SW] = m_samp[k][SW-1:0];
            end
        end
        return w;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic          xfer;
        logic          emit;
        logic [DW-1:0] word;
        int            cap;
        xfer = e_valid && dout_ready;
        emit = 1'b0;
        word = '0;
        if (m_n == 0) m_mode = mode;
        if (wen) begin
            m_samp[m_n] = din;
            m_n++;
        end
        cap = (m_mode == 1'b1) ? SLOTS : DEPTH;
        if ((m_n == cap) || (flush && m_n > 0)) begin
            emit = 1'b1;
            word = build_word(m_mode, m_n);
            m_n  = 0;
        end
        if (emit) begin
            if (!e_valid || dout_ready) begin
                e_dout = word; e_valid = 1'b1;
            end else begin
                e_ovf = 1'b1;
                if (e_drop < 255) e_drop++;
            end
        end else if (xfer) begin
            e_valid = 1'b0;
        end
        if (clr_ovf) begin
            e_ovf = 1'b0; e_drop = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, e_valid, e_dout, e_ovf, 8'(e_drop));
    endtask

    task automatic do_reset();
        wen = 1'b0; flush = 1'b0; clr_ovf = 1'b0; dout_ready = 1'b0; mode = 1'b0;
        clr = 1'b0;
        tick();
        clr = 1'b1;
        model_reset();
    endtask

    initial begin
        // Directed table: fresh state after reset at the start of the table.
        add_vec(1, 64'h4444_3333_2222_1111, 0, 0, 1, 0, 0, '0, 0, 0);
        add_vec(1, 64'h8888_7777_6666_5555, 0, 0, 1, 0, 1, W35, 0, 0);
        add_vec(0, '0, 0, 0, 1, 0, 0, W35, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            add_vec(1, {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'(k)}, (k == 3) ? 1'b0 : 1'b1, 0, 1, 0,
                    (k == 8), (k == 8) ? W36 : W35, 0, 0);
        end
        add_vec(0, '0, 0, 0, 1, 0, 0, W36, 0, 0);
        add_vec(1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 1, 0, 0, W36, 0, 0);
        add_vec(0, '0, 0, 1, 1, 0, 1, W38, 0, 0);
        add_vec(0, '0, 0, 1, 1, 0, 0, W38, 0, 0);
        add_vec(0, '0, 0, 1, 1, 0, 0, W38, 0, 0);
        add_vec(1, 64'h0004_0003_0002_0001, 0, 0, 0, 0, 0, W38, 0, 0);
        add_vec(1, 64'h0008_0007_0006_0005, 0, 0, 0, 0, 1, W37, 0, 0);
        add_vec(1, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 1, W37, 0, 0);
        add_vec(1, 64'h0F0F_F0F0_5A5A_A5A5, 0, 0, 0, 0, 1, W37, 1, 1);
        add_vec(1, 64'hCAFE_BABE_DEAD_BEEF, 0, 0, 0, 0, 1, W37, 1, 1);
        add_vec(1, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 1, W37, 1, 2);
        add_vec(0, '0, 0, 0, 0, 1, 1, W37, 0, 0);
        add_vec(1, 64'h00D0_00C0_00B0_00A0, 0, 0, 0, 0, 1, W37, 0, 0);
        add_vec(1, 64'h00D1_00C1_00B1_00A1, 0, 0, 1, 0, 1, W40, 0, 0);
        add_vec(0, '0, 0, 0, 1, 0, 0, W40, 0, 0);

        #12;
        check_outs("reset", 1'b0, '0, 1'b0, 8'd0);
        tick();
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            wen = vecs[i].wen; din = vecs[i].din; mode = vecs[i].mode;
            flush = vecs[i].flush; dout_ready = vecs[i].ready; clr_ovf = vecs[i].clr_ovf;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eo, vecs[i].edc);
        end

        // Asynchronous reset mid-word with a pending output word.
        wen = 1'b1; mode = 1'b0; flush = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0;
        din = 64'h0004_0003_0002_0001; tick();
        din = 64'h0008_0007_0006_0005; tick();
        din = 64'hDEAD_DEAD_DEAD_DEAD; tick();
        wen = 1'b0;
        #2 clr = 1'b0;
        #1;
        check_outs("async_clr", 1'b0, '0, 1'b0, 8'd0);
        #3 clr = 1'b1;
        wen = 1'b1; dout_ready = 1'b1;
        din = 64'h4444_3333_2222_1111; tick();
        chk("post_clr.first_valid", DW'(dout_valid), DW'(1'b0));
        din = 64'h8888_7777_6666_5555; tick();
        check_outs("post_clr.word", 1'b1, W35, 1'b0, 8'd0);

        // Drop counter saturation, then clr_ovf winning over a new drop.
        do_reset();
        for (int i = 0; i < 2 * 257; i++) begin
            wen = 1'b1; din = {$urandom, $urandom};
            model_step();
            tick();
        end
        check_model("sat.model");
        chk("sat.drop_cnt", DW'(drop_cnt), DW'(8'd255));
        chk("sat.overflow", DW'(overflow), DW'(1'b1));
        wen = 1'b1; din = {$urandom, $urandom}; model_step(); tick();
        clr_ovf = 1'b1; din = {$urandom, $urandom}; model_step(); tick();
        chk("clr_prio.overflow", DW'(overflow), DW'(1'b0));
        chk("clr_prio.drop_cnt", DW'(drop_cnt), DW'(8'd0));
        check_model("clr_prio.model");
        clr_ovf = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wen        = ($urandom_range(0, 3) != 0);
            din        = {$urandom, $urandom};
            mode       = ($urandom_range(0, 5) == 0) ? ~mode : mode;
            flush      = ($urandom_range(0, 7) == 0);
            dout_ready = ($urandom_range(0, 1) == 0);
            clr_ovf    = ($urandom_range(0, 31) == 0);
            model_step();
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
